slot_bus_ctrl: RTL and testbench

SLOT_BUS_CTRL -- requirements
Module: slot_bus_ctrl

---
 rtl/slot_bus_pkg.sv | 14 +
 rtl/bus_sync.sv | 26 ++
 rtl/slot_bus_ctrl.sv | 145 ++++++++++++++
 tb/tb_slot_bus_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/slot_bus_pkg.sv
// rtl/slot_bus_pkg.sv - shared types and constants for the cartridge slot bus controller.
package slot_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [7:0] OPEN_BUS        = 8'hFF;
  localparam int         DEF_TIMEOUT     = 15;
  localparam int         DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/bus_sync.sv
// rtl/bus_sync.sv - multi-bit flop-chain synchronizer for asynchronous bus strobes.
// Resets to all ones so idle (high) active-low strobes never glitch a cycle start.
module bus_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '1;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[STAGES-1];

endmodule

// File: rtl/slot_bus_ctrl.sv
// rtl/slot_bus_ctrl.sv - cartridge slot bus cycle controller (IDLE/ACCESS/HOLD).
// Build option: define SLOT_WAIT_EN to stretch ACCESS with wait_n from its second cycle.
module slot_bus_ctrl
  import slot_bus_pkg::*;
#(
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sltsl_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [15:0] addr,
  input  logic [7:0]  cdin,
  output logic        cyc_en,
  output logic        cyc_rd,
  output logic        cyc_wr,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  exp_cdout,
  input  logic        exp_busreq,
  input  logic [3:0]  slotsel,
  input  logic [3:0]  dev_ack,
  input  logic [31:0] dev_data,
  output logic [7:0]  cdout,
  output logic        busdir,
  output logic        wait_n,
  output logic        timeout_err
);

  localparam int            CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  state_t        state, state_next;
  logic [2:0]    strobes, synced;
  logic          s_sltsl_n, s_rd_n, s_wr_n;
  logic [CW-1:0] count;
  logic          is_rd;
  logic          start, hit, expired, hold_exit;
  logic [7:0]    win_data;

  assign strobes = {sltsl_n, rd_n, wr_n};

  bus_sync #(
    .WIDTH (3),
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .din  (strobes),
    .dout (synced)
  );

  assign s_sltsl_n = synced[2];
  assign s_rd_n    = synced[1];
  assign s_wr_n    = synced[0];

  assign start     = !s_sltsl_n && (s_rd_n != s_wr_n);
  assign expired   = (count == LAST);
  assign hold_exit = s_sltsl_n || (s_rd_n && s_wr_n);

  // Expander response outranks devices; among devices the lowest subslot wins.
  always_comb begin
    hit      = 1'b0;
    win_data = OPEN_BUS;
    for (int i = 3; i >= 0; i--) begin
      if (slotsel[i] && dev_ack[i]) begin
        hit      = 1'b1;
        win_data = dev_data[8*i +: 8];
      end
    end
    if (exp_busreq) begin
      hit      = 1'b1;
      win_data = exp_cdout;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ACCESS;
      ACCESS: begin
        if (s_sltsl_n)           state_next = IDLE;
        else if (hit || expired) state_next = HOLD;
      end
      HOLD:    if (hold_exit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A slot release during ACCESS aborts silently: no data, no error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      count       <= '0;
      is_rd       <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      cdout       <= OPEN_BUS;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bus_addr  <= addr;
            bus_wdata <= cdin;
            is_rd     <= !s_rd_n;
            count     <= '0;
          end
        end
        ACCESS: begin
          if (!s_sltsl_n) begin
            if (hit) begin
              if (is_rd) cdout <= win_data;
            end else if (expired) begin
              if (is_rd) cdout <= OPEN_BUS;
              timeout_err <= 1'b1;
            end else begin
              count <= count + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cyc_en = (state == ACCESS) && (count == '0);
    cyc_rd = (state != IDLE) && is_rd;
    cyc_wr = (state != IDLE) && !is_rd;
    busdir = (state == HOLD) && is_rd && !hold_exit;
`ifdef SLOT_WAIT_EN
    wait_n = !((state == ACCESS) && (count != '0));
`else
    wait_n = 1'b1;
`endif
  end

endmodule

// File: tb/tb_slot_bus_ctrl.sv
// tb/tb_slot_bus_ctrl.sv - self-checking bench for slot_bus_ctrl: vector table, directed corners, random model.
module tb_slot_bus_ctrl;

  localparam int TIMEOUT = 15;

  logic        clk, reset;
  logic        sltsl_n, rd_n, wr_n;
  logic [15:0] addr;
  logic [7:0]  cdin;
  logic        cyc_en, cyc_rd, cyc_wr;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic [7:0]  exp_cdout;
  logic        exp_busreq;
  logic [3:0]  slotsel, dev_ack;
  logic [31:0] dev_data;
  logic [7:0]  cdout;
  logic        busdir, wait_n, timeout_err;

  int n_checks = 0;
  int n_fail   = 0;
  int en_count = 0;

  slot_bus_ctrl #(.TIMEOUT(TIMEOUT), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .sltsl_n(sltsl_n), .rd_n(rd_n), .wr_n(wr_n),
    .addr(addr), .cdin(cdin), .cyc_en(cyc_en), .cyc_rd(cyc_rd), .cyc_wr(cyc_wr),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .exp_cdout(exp_cdout),
    .exp_busreq(exp_busreq), .slotsel(slotsel), .dev_ack(dev_ack),
    .dev_data(dev_data), .cdout(cdout), .busdir(busdir), .wait_n(wait_n),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (cyc_en === 1'b1) en_count++;
  end

  typedef struct {
    bit          rd;
    logic [15:0] a;
    logic [7:0]  wd;
    int          d;
    bit          breq;
    logic [7:0]  bdata;
    logic [3:0]  sel;
    logic [3:0]  ack;
    logic [31:0] ddata;
    logic [7:0]  exp_cd;
    bit          exp_te;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pick(input bit breq, input logic [7:0] bdata,
                                      input logic [3:0] sel, input logic [3:0] ack,
                                      input logic [31:0] ddata);
    if (breq) return bdata;
    for (int i = 0; i < 4; i++)
      if (sel[i] && ack[i]) return ddata[8*i +: 8];
    return 8'hFF;
  endfunction

  // One full bus cycle: start, respond after d cycles, check ACCESS/HOLD behaviour, release.
  task automatic run_txn(input bit rd, input logic [15:0] a, input logic [7:0] wd, input int d,
                         input bit breq, input logic [7:0] bdata, input logic [3:0] sel,
                         input logic [3:0] ack, input logic [31:0] ddata,
                         input logic [7:0] exp_cd, input bit exp_te, input bit by_slot);
    bit seen, complete, exp_wait;
    int end_c, en0;
    complete = (breq || (|(sel & ack))) && (d + 1 <= TIMEOUT);
    end_c    = complete ? d + 1 : TIMEOUT;
    en0      = en_count;
    addr = a; cdin = wd; exp_cdout = bdata; slotsel = sel; dev_data = ddata;
    exp_busreq = 1'b0; dev_ack = 4'h0;
    sltsl_n = 1'b0; rd_n = !rd; wr_n = rd;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      seen = cyc_en;
    end
    check("cyc_start", 64'(seen), 64'(1));
    addr = ~a; cdin = ~wd;
    for (int c = 1; c <= TIMEOUT + 2; c++) begin
      if (c == d + 1) begin
        exp_busreq = breq;
        dev_ack    = ack;
      end
      exp_wait = 1'b1;
`ifdef SLOT_WAIT_EN
      if (c >= 2 && c <= end_c) exp_wait = 1'b0;
`endif
      check("busdir_cycle", 64'(busdir), 64'((c > end_c) && rd));
      check("wait_n_cycle", 64'(wait_n), 64'(exp_wait));
      @(negedge clk);
    end
    check("hold_cdout", 64'(cdout), 64'(exp_cd));
    check("timeout_err", 64'(timeout_err), 64'(exp_te));
    check("latched", 64'({bus_addr, bus_wdata, cyc_rd, cyc_wr}), 64'({a, wd, rd, !rd}));
    exp_busreq = 1'b0; dev_ack = 4'h0;
    if (by_slot) sltsl_n = 1'b1;
    else begin rd_n = 1'b1; wr_n = 1'b1; end
    @(negedge clk);
    check("hold_busdir", 64'(busdir), 64'(rd));
    @(negedge clk);
    check("exit_drop", 64'({busdir, cyc_rd, cyc_wr}), 64'({1'b0, rd, !rd}));
    @(negedge clk);
    check("back_idle", 64'({cyc_rd, cyc_wr, busdir, wait_n}), 64'(4'b0001));
    check("one_cyc_en", 64'(en_count - en0), 64'(1));
    sltsl_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  localparam logic [37:0] RESET_VEC = {5'b00001, 1'b0, 8'hFF, 16'h0000, 8'h00};

  initial begin
    bit          seen, rd, breq, by_slot, valid, complete;
    int          en0, d;
    logic [7:0]  m_cdout, bdata, wd;
    logic        m_terr;
    logic [3:0]  sel, ack;
    logic [15:0] a;
    logic [31:0] ddata;

    tbl[0] = '{1'b1, 16'hFFFF, 8'h00, 1,  1'b1, 8'h5A, 4'b0000, 4'b0000, 32'h0,        8'h5A, 1'b0};
    tbl[1] = '{1'b0, 16'h4000, 8'h3C, 3,  1'b0, 8'h00, 4'b0010, 4'b0010, 32'h0,        8'h5A, 1'b0};
    tbl[2] = '{1'b1, 16'h8123, 8'h00, 0,  1'b0, 8'h00, 4'b1001, 4'b1001, 32'h33224411, 8'h11, 1'b0};
    tbl[3] = '{1'b1, 16'h0001, 8'h00, 2,  1'b1, 8'hA5, 4'b1111, 4'b0100, 32'h0,        8'hA5, 1'b0};
    tbl[4] = '{1'b1, 16'h7FFE, 8'h00, 4,  1'b0, 8'h00, 4'b0110, 4'b1100, 32'h44776655, 8'h77, 1'b0};
    tbl[5] = '{1'b1, 16'hC000, 8'h00, 14, 1'b1, 8'h3E, 4'b0000, 4'b0000, 32'h0,        8'h3E, 1'b0};
    tbl[6] = '{1'b0, 16'h1234, 8'h99, 0,  1'b0, 8'h00, 4'b0001, 4'b0010, 32'hFFFFFFFF, 8'h3E, 1'b1};
    tbl[7] = '{1'b1, 16'h5555, 8'h00, 0,  1'b0, 8'h00, 4'b0000, 4'b0000, 32'h0,        8'hFF, 1'b1};

    reset = 1'b1; sltsl_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    addr = 16'h0; cdin = 8'h0; exp_cdout = 8'h0; exp_busreq = 1'b0;
    slotsel = 4'h0; dev_ack = 4'h0; dev_data = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_state", 64'({cyc_en, cyc_rd, cyc_wr, busdir, wait_n, timeout_err, cdout, bus_addr, bus_wdata}),
          64'(RESET_VEC));
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++)
      run_txn(tbl[i].rd, tbl[i].a, tbl[i].wd, tbl[i].d, tbl[i].breq, tbl[i].bdata, tbl[i].sel,
              tbl[i].ack, tbl[i].ddata, tbl[i].exp_cd, tbl[i].exp_te, i[0]);

    // Both strobes low together must never start a cycle.
    en0 = en_count;
    sltsl_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0;
    repeat (8) @(negedge clk);
    check("both_low_no_cyc", 64'(en_count - en0), 64'(0));
    check("both_low_idle", 64'({cyc_rd, cyc_wr, busdir}), 64'(0));
    sltsl_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    repeat (3) @(negedge clk);

    // Reset while holding read data on the bus.
    exp_busreq = 1'b1; exp_cdout = 8'h77;
    sltsl_n = 1'b0; rd_n = 1'b0; wr_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      seen = cyc_en;
    end
    check("rst_hold_start", 64'(seen), 64'(1));
    @(negedge clk);
    check("rst_hold_busdir", 64'({busdir, cdout}), 64'({1'b1, 8'h77}));
    reset = 1'b1;
    en0 = en_count;
    @(negedge clk);
    check("rst_in_hold", 64'({cyc_en, cyc_rd, cyc_wr, busdir, wait_n, timeout_err, cdout, bus_addr, bus_wdata}),
          64'(RESET_VEC));
    repeat (3) @(negedge clk);
    check("rst_no_cyc_en", 64'(en_count - en0), 64'(0));
    exp_busreq = 1'b0; sltsl_n = 1'b1; rd_n = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_release_idle", 64'({en_count - en0, 32'(busdir)}), 64'(0));

    // Slot released mid-ACCESS: abort without error.
    en0 = en_count;
    slotsel = 4'hF; sltsl_n = 1'b0; rd_n = 1'b0; wr_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      seen = cyc_en;
    end
    check("abort_start", 64'(seen), 64'(1));
    sltsl_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_idle", 64'({cyc_rd, cyc_wr, busdir, wait_n, timeout_err}), 64'(5'b00010));
    check("abort_cdout", 64'(cdout), 64'(8'hFF));
    rd_n = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_one_en", 64'(en_count - en0), 64'(1));

    m_cdout = 8'hFF;
    m_terr  = 1'b0;
    for (int n = 0; n < 40; n++) begin
      rd      = 1'($urandom_range(0, 1));
      a       = 16'($urandom);
      wd      = 8'($urandom);
      d       = int'($urandom_range(0, 17));
      breq    = ($urandom_range(0, 3) == 0);
      bdata   = 8'($urandom);
      sel     = 4'($urandom);
      ack     = 4'($urandom);
      ddata   = $urandom;
      by_slot = 1'($urandom_range(0, 1));
      valid    = breq || (|(sel & ack));
      complete = valid && (d + 1 <= TIMEOUT);
      if (rd) m_cdout = complete ? pick(breq, bdata, sel, ack, ddata) : 8'hFF;
      if (!complete) m_terr = 1'b1;
      run_txn(rd, a, wd, d, breq, bdata, sel, ack, ddata, m_cdout, m_terr, by_slot);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
